// File: rtl/ram16x4_arbiter.sv
// Round-robin arbiter sharing one single-port 16x4 RAM between two req/ack requesters.
// Optional post-reset init sweep of every RAM word is compiled in with `define RAM16X4_ARB_INIT_EN.
module ram16x4_arbiter #(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e              state_q,     state_d;
  logic                last_gnt_q,  last_gnt_d;   // 1 = port B granted last
  logic                gnt_b_q,     gnt_b_d;      // winner of the access in flight
  logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
  logic                ram_we_q,    ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   rdata_q,     rdata_d;
  logic                a_ack_q,     a_ack_d;
  logic                b_ack_q,     b_ack_d;
  logic                pick_b;

`ifdef RAM16X4_ARB_INIT_EN
  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] INIT_LAST = (ADDR_W + 1)'(DEPTH);
  localparam state_e          RST_STATE = ST_INIT;
  logic [ADDR_W:0]            init_cnt_q, init_cnt_d;
`else
  localparam state_e          RST_STATE = ST_IDLE;
`endif

  // NOTE: every state register uses non-blocking assignment so all flops
  // update together from the values computed before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      last_gnt_q  <= 1'b1;
      gnt_b_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
`ifdef RAM16X4_ARB_INIT_EN
      init_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_b_q     <= gnt_b_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
`ifdef RAM16X4_ARB_INIT_EN
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end

  // On a tie the port that did not win last time takes the grant.
  assign pick_b = b_req & (~a_req | ~last_gnt_q);

  // NOTE: every variable gets a default before the case so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_b_d     = gnt_b_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
`ifdef RAM16X4_ARB_INIT_EN
    init_cnt_d  = init_cnt_q;
`endif

    unique case (state_q)
`ifdef RAM16X4_ARB_INIT_EN
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          ram_addr_d = '0;
          state_d    = ST_IDLE;
        end else begin
          ram_we_d    = 1'b1;
          ram_addr_d  = init_cnt_q[ADDR_W-1:0];
          ram_wdata_d = INIT_VAL;
          init_cnt_d  = init_cnt_q + 1'b1;
        end
      end
`endif
      ST_IDLE: begin
        if (a_req || b_req) begin
          gnt_b_d     = pick_b;
          last_gnt_d  = pick_b;
          ram_addr_d  = pick_b ? b_addr  : a_addr;
          ram_we_d    = pick_b ? b_we    : a_we;
          ram_wdata_d = pick_b ? b_wdata : a_wdata;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // The external RAM commits a write at this same edge; only reads load rdata.
        if (!ram_we_q) begin
          rdata_d = ram_rdata;
        end
        a_ack_d = ~gnt_b_q;
        b_ack_d = gnt_b_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef RAM16X4_ARB_INIT_EN
  assign init_done = (state_q != ST_INIT);
`else
  assign init_done = 1'b1;
`endif

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign rdata     = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram16x4_arbiter.sv
// Self-checking bench for ram16x4_arbiter: directed scenarios plus random rounds,
// checked against a transaction-level model of the shared RAM and round-robin rule.
module tb_ram16x4_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_ack, b_ack, init_done, ram_we;
  logic [3:0] rdata, ram_addr, ram_wdata, ram_rdata;

  // Storage array the arbiter drives: synchronous write, combinational read.
  logic [3:0] mem [16] = '{4'h9, 4'h8, 4'hB, 4'hA, 4'hD, 4'hC, 4'hF, 4'hE,
                           4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'h4, 4'h7, 4'h6};
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  // Reference model state.
  logic [3:0] ref_mem [16];
  logic [3:0] m_rdata;
  logic       m_last_b;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  ram16x4_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .rdata(rdata), .init_done(init_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
`ifdef RAM16X4_ARB_INIT_EN
    int   n;
    int   got;
    logic early_ack;
`endif
    rst_n = 1'b0;
    #1;
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_wdata", ram_wdata, 0);
`ifdef RAM16X4_ARB_INIT_EN
    check("rst_init_done", init_done, 0);
`else
    check("rst_init_done", init_done, 1);
`endif
    m_rdata  = 4'h0;
    m_last_b = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
`ifdef RAM16X4_ARB_INIT_EN
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd7;
`endif
    rst_n = 1'b1;
`ifdef RAM16X4_ARB_INIT_EN
    n = 0;
    early_ack = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (init_done) break;
      if (a_ack || b_ack) early_ack = 1'b1;
      if (ram_we) begin
        check("init_addr", ram_addr, n);
        check("init_wdata", ram_wdata, 4'h0);
        n++;
      end
    end
    check("init_pulses", n, 16);
    check("init_done", init_done, 1);
    check("init_end_we", ram_we, 0);
    check("init_end_addr", ram_addr, 0);
    check("init_no_ack", early_ack, 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
    got = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (a_ack) begin got = c; break; end
    end
    check("init_req_lat", got, 2);
    check("init_req_rdata", rdata, 4'h0);
    m_rdata  = 4'h0;
    m_last_b = 1'b0;
    a_req = 1'b0;
`endif
  endtask

  // One arbitration round: raise the selected requests together and check
  // every grant against the round-robin rule and the reference memory.
  task automatic do_round(input logic ra, input logic wa, input logic [3:0] aa, input logic [3:0] da,
                          input logic rb, input logic wb, input logic [3:0] ab, input logic [3:0] db);
    logic       first_b, cur_b, we, pw;
    logic [3:0] ad, dd, pa, pd;
    int         n, got;
    @(negedge clk);
    a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
    b_req = rb; b_we = wb; b_addr = ab; b_wdata = db;
    n = int'(ra) + int'(rb);
    first_b = (ra && rb) ? !m_last_b : rb;
    for (int k = 0; k < n; k++) begin
      cur_b = (k == 0) ? first_b : !first_b;
      we = cur_b ? wb : wa;
      ad = cur_b ? ab : aa;
      dd = cur_b ? db : da;
      got = 0; pw = 1'b0; pa = 4'h0; pd = 4'h0;
      for (int c = 1; c <= 8; c++) begin
        pw = ram_we; pa = ram_addr; pd = ram_wdata;
        @(negedge clk);
        if (a_ack || b_ack) begin got = c; break; end
      end
      check("latency", got, (k == 0) ? 2 : 3);
      check("a_ack", a_ack, !cur_b);
      check("b_ack", b_ack, cur_b);
      check("ram_we_access", pw, we);
      check("ram_addr_access", pa, ad);
      if (we) begin
        check("ram_wdata_access", pd, dd);
        ref_mem[ad] = dd;
      end else begin
        m_rdata = ref_mem[ad];
      end
      check("ram_we_resp", ram_we, 0);
      check("rdata", rdata, m_rdata);
      m_last_b = cur_b;
      if (cur_b) b_req = 1'b0; else a_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         acks, gap;
    logic       exp_b, ra, rb;
    rst_n = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 4'h0; a_wdata = 4'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 4'h0; b_wdata = 4'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 4'(i) ^ 4'h9;
    #2;
    do_reset();

    // Simultaneous first requests: A reads 3, B writes 7 there; then re-read.
    do_round(1'b1, 1'b0, 4'd3, 4'h0, 1'b1, 1'b1, 4'd3, 4'h7);
    do_round(1'b1, 1'b0, 4'd3, 4'h0, 1'b0, 1'b0, 4'd0, 4'h0);
    check("reread_3", rdata, 4'h7);

    // Port A write then read of address 5.
    do_round(1'b1, 1'b1, 4'd5, 4'hA, 1'b0, 1'b0, 4'd0, 4'h0);
    do_round(1'b1, 1'b0, 4'd5, 4'h0, 1'b0, 1'b0, 4'd0, 4'h0);
    check("read_5", rdata, 4'hA);

    // A port B write must leave the last read data in place.
    do_round(1'b1, 1'b1, 4'd6, 4'h3, 1'b0, 1'b0, 4'd0, 4'h0);
    do_round(1'b1, 1'b0, 4'd6, 4'h0, 1'b0, 1'b0, 4'd0, 4'h0);
    do_round(1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 1'b1, 4'd10, 4'hC);
    repeat (2) @(negedge clk);
    check("rdata_hold", rdata, 4'h3);

    // Both requests held: grants must alternate with a fixed 3-cycle spacing.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    exp_b = !m_last_b;
    acks = 0;
    gap = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      gap++;
      check("fair_one_ack", a_ack && b_ack, 0);
      if (a_ack || b_ack) begin
        check("fair_port", b_ack, exp_b);
        check("fair_gap", gap, (acks == 0) ? 2 : 3);
        m_rdata = ref_mem[exp_b ? 2 : 1];
        check("fair_rdata", rdata, m_rdata);
        m_last_b = exp_b;
        exp_b = !exp_b;
        acks++;
        gap = 0;
        if (acks == 4) begin
          a_req = 1'b0;
          b_req = 1'b0;
          break;
        end
      end
    end
    check("fair_count", acks, 4);
    repeat (3) @(negedge clk);
    check("fair_quiet", a_ack || b_ack, 0);

    // Random rounds.
    for (int r = 0; r < 24; r++) begin
      ra = 1'($urandom_range(0, 1));
      rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
      do_round(ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               rb, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Reset during the access cycle of a write aborts it.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd9; a_wdata = 4'hE;
    @(negedge clk);
    check("midop_ram_we", ram_we, 1);
    check("midop_ram_addr", ram_addr, 9);
    a_req = 1'b0;
    do_reset();
    do_round(1'b1, 1'b0, 4'd9, 4'h0, 1'b0, 1'b0, 4'd0, 4'h0);
    do_round(1'b1, 1'b1, 4'd9, 4'hE, 1'b0, 1'b0, 4'd0, 4'h0);
    do_round(1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 1'b0, 4'd9, 4'h0);
    check("post_reset_read_9", rdata, 4'hE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram16x4_arbiter.md
Name: ram16x4_arbiter

Overview:
Two-requester round-robin arbiter sharing one single-port 16x4 RAM (synchronous write, combinational read) between port A and port B. Each requester uses a req/ack handshake for single-word reads or writes. The arbiter owns every RAM control signal and returns read data in a registered holding register. It sits between the requesters and the 16x4 storage array.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W
DATA_W, 4, RAM word width
INIT_VAL, 4'b0000, word written to every location by the init sweep (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_req  in  1  port A request; held high with a_we/a_addr/a_wdata stable until a_ack
a_we  in  1  port A: 1 = write, 0 = read
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_ack  out  1  port A one-cycle completion pulse
b_req, b_we, b_addr, b_wdata, b_ack  same as port A, for port B
rdata  out  DATA_W  read data from the last completed read; valid while a_ack or b_ack is high; holds otherwise
init_done  out  1  high when the arbiter accepts requests
ram_addr  out  ADDR_W  RAM address, registered
ram_we  out  1  RAM write enable, registered
ram_wdata  out  DATA_W  RAM write data, registered
ram_rdata  in  DATA_W  RAM combinational read data

Behaviour:
- States: INIT (optional feature only), IDLE, ACCESS, RESP.
- Reset (async, rst_n low): a_ack=0, b_ack=0, rdata=0, ram_addr=0, ram_we=0, ram_wdata=0, last_gnt=B (port A wins first tie). State goes to INIT if the feature is compiled in, otherwise IDLE. Reset mid-transaction aborts it with no ack; the requester must reissue.
- IDLE: on a clock edge with any req high, pick a winner.
  - Single requester: that requester wins.
  - Both requesting: the requester not in last_gnt wins.
  - Load ram_addr/ram_we/ram_wdata from the winner, update last_gnt, go to ACCESS.
  - With no req, the RAM outputs hold and ram_we=0.
- ACCESS (1 cycle): RAM sees the granted operation.
  - At the closing edge: if the operation was a write, the RAM writes. If it was a read, rdata <= ram_rdata; a write leaves rdata unchanged.
  - ram_we <= 0, winner's ack <= 1, go to RESP.
- RESP (1 cycle): ack high; at the closing edge ack <= 0, go to IDLE.
- Requester deasserts req in the cycle after ack, or may keep it high to issue a new request that re-enters arbitration in IDLE.
- Timing: req sampled at edge N; ack high in cycle N+2; peak throughput is one access per 3 cycles.
- Fairness: under continuous requests from both ports, grants alternate strictly A, B, A, B.
- Only one ack is high in any cycle. Requests arriving during ACCESS/RESP wait; req changes while not granted are legal.
- Address is ADDR_W bits with no range check; all 16 locations are valid.

Optional Feature:
RAM16X4_ARB_INIT_EN
- Defined: after reset the state is INIT and init_done=0. Each cycle drives ram_we=1 and ram_wdata=INIT_VAL, with ram_addr stepping 0..15 (addr 0 in the first cycle after reset release), for 16 cycles. After the write to addr 15, go to IDLE with ram_we=0, ram_addr=0, init_done=1. Requests during INIT are ignored (no ack) and are served in order once IDLE is reached.
- Undefined: no INIT state; IDLE directly after reset; init_done is constant 1; RAM contents are not touched by reset.

Test Plan:
- Write then read, port A: a_req with we=1, addr=5, wdata=4'hA -> a_ack high exactly 2 cycles after the sampling edge, ram_we high for one cycle with ram_addr=5. Then read addr=5 -> rdata=4'hA during a_ack.
- Simultaneous first requests after reset: both req at the same edge (A read addr 3, B write addr 3 data 4'h7) -> A acked first with the old data, B acked 3 cycles later. A re-read returns 4'h7.
- Fairness: both reqs held high for 12 cycles -> acks alternate A, B, A, B; never two acks in the same cycle; no ack gap longer than 3 cycles.
- Write to port B does not disturb rdata: read returns 4'h3, then a B write of 4'hC to another address -> rdata stays 4'h3 after b_ack.
- Reset mid-operation: assert rst_n=0 during ACCESS of a write -> all outputs at reset values immediately, no ack. Re-request after release completes normally.
- With RAM16X4_ARB_INIT_EN: release reset -> 16 consecutive ram_we pulses, addrs 0..15, data INIT_VAL, then init_done=1. A request raised during INIT is acked only after init_done. A read of any address returns INIT_VAL.
